// File: rtl/game_status_pkg.sv
// Shared types and constants for the game-status encoder and the status-LED driver.
package game_status_pkg;

    typedef enum logic [1:0] {
        GS_PAUSED = 2'b00,
        GS_WIN    = 2'b01,
        GS_LOSE   = 2'b10,
        GS_RUN    = 2'b11
    } game_state_t;

    // RGB colours the LED driver shows per code; running shows the LED off.
    localparam logic [2:0] LED_PAUSED = 3'b001;
    localparam logic [2:0] LED_WIN    = 3'b010;
    localparam logic [2:0] LED_LOSE   = 3'b100;
    localparam logic [2:0] LED_OFF    = 3'b000;

    function automatic int hold_timer_w(input int hold_cycles);
        int w;
        w = $clog2(hold_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/game_state_fsm.sv
// One game: lifecycle FSM, WIN/LOSE hold timer and win/loss counters.
// Counters exist only when GAME_STATUS_SCORE_EN is defined; otherwise the score outputs are 0.
module game_state_fsm
    import game_status_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int SCORE_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pause,
    input  logic               win,
    input  logic               lose,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] wins,
    output logic [SCORE_W-1:0] losses
);

    localparam int TW = hold_timer_w(HOLD_CYCLES);
    localparam logic [TW-1:0] LAST = (HOLD_CYCLES > 0) ? TW'(HOLD_CYCLES - 1) : '0;
    localparam bit HOLD_EN = (HOLD_CYCLES > 0);

    game_state_t cur, nxt;
    logic [TW-1:0] timer;
    logic          holding;
    logic          expire;

    assign holding = (cur == GS_WIN) || (cur == GS_LOSE);
    assign expire  = HOLD_EN && (timer == LAST);

    always_comb begin
        nxt = cur;
        case (cur)
            GS_PAUSED: if (start || pause) nxt = GS_RUN;
            GS_RUN: begin
                if (lose)       nxt = GS_LOSE;
                else if (win)   nxt = GS_WIN;
                else if (pause) nxt = GS_PAUSED;
            end
            GS_WIN, GS_LOSE: begin
                if (start)       nxt = GS_RUN;
                else if (expire) nxt = GS_PAUSED;
            end
            default: nxt = GS_PAUSED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur   <= GS_PAUSED;
            timer <= '0;
        end else begin
            cur <= nxt;
            // Timer restarts on any state change; with no hold limit it stays at zero.
            if (HOLD_EN && holding && (nxt == cur))
                timer <= timer + 1'b1;
            else
                timer <= '0;
        end
    end

    assign state = cur;

`ifdef GAME_STATUS_SCORE_EN
    logic to_win, to_lose;
    assign to_win  = (cur == GS_RUN) && (nxt == GS_WIN);
    assign to_lose = (cur == GS_RUN) && (nxt == GS_LOSE);

    always_ff @(posedge clk) begin
        if (rst) begin
            wins   <= '0;
            losses <= '0;
        end else begin
            if (to_win && (wins != '1))
                wins <= wins + 1'b1;
            if (to_lose && (losses != '1))
                losses <= losses + 1'b1;
        end
    end
`else
    assign wins   = '0;
    assign losses = '0;
`endif

endmodule

// File: rtl/game_status_encoder.sv
// Two independent game-status FSMs driving the 2-bit LED status codes.
// Optional score counters are enabled with GAME_STATUS_SCORE_EN.
module game_status_encoder
    import game_status_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int SCORE_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               g1_start,
    input  logic               g1_pause,
    input  logic               g1_win,
    input  logic               g1_lose,
    input  logic               g2_start,
    input  logic               g2_pause,
    input  logic               g2_win,
    input  logic               g2_lose,
    output logic [1:0]         game1_state,
    output logic [1:0]         game2_state,
    output logic [SCORE_W-1:0] g1_wins,
    output logic [SCORE_W-1:0] g1_losses,
    output logic [SCORE_W-1:0] g2_wins,
    output logic [SCORE_W-1:0] g2_losses
);

    game_state_fsm #(.HOLD_CYCLES(HOLD_CYCLES), .SCORE_W(SCORE_W)) u_game1 (
        .clk    (clk),
        .rst    (rst),
        .start  (g1_start),
        .pause  (g1_pause),
        .win    (g1_win),
        .lose   (g1_lose),
        .state  (game1_state),
        .wins   (g1_wins),
        .losses (g1_losses)
    );

    game_state_fsm #(.HOLD_CYCLES(HOLD_CYCLES), .SCORE_W(SCORE_W)) u_game2 (
        .clk    (clk),
        .rst    (rst),
        .start  (g2_start),
        .pause  (g2_pause),
        .win    (g2_win),
        .lose   (g2_lose),
        .state  (game2_state),
        .wins   (g2_wins),
        .losses (g2_losses)
    );

endmodule

// File: tb/tb_game_status_encoder.sv
// Directed self-checking bench: HOLD_CYCLES=4 instance plus a HOLD_CYCLES=0 instance.
module tb_game_status_encoder;

`ifdef GAME_STATUS_SCORE_EN
    localparam int SC = 1;
`else
    localparam int SC = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic g1_start = 0, g1_pause = 0, g1_win = 0, g1_lose = 0;
    logic g2_start = 0, g2_pause = 0, g2_win = 0, g2_lose = 0;

    logic [1:0] game1_state, game2_state, h0_game1_state, h0_game2_state;
    logic [1:0] g1_wins, g1_losses, g2_wins, g2_losses;
    logic [1:0] h0_g1_wins, h0_g1_losses, h0_g2_wins, h0_g2_losses;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    game_status_encoder #(.HOLD_CYCLES(4), .SCORE_W(2)) dut (
        .clk(clk), .rst(rst),
        .g1_start(g1_start), .g1_pause(g1_pause), .g1_win(g1_win), .g1_lose(g1_lose),
        .g2_start(g2_start), .g2_pause(g2_pause), .g2_win(g2_win), .g2_lose(g2_lose),
        .game1_state(game1_state), .game2_state(game2_state),
        .g1_wins(g1_wins), .g1_losses(g1_losses), .g2_wins(g2_wins), .g2_losses(g2_losses)
    );

    game_status_encoder #(.HOLD_CYCLES(0), .SCORE_W(2)) dut_h0 (
        .clk(clk), .rst(rst),
        .g1_start(g1_start), .g1_pause(g1_pause), .g1_win(g1_win), .g1_lose(g1_lose),
        .g2_start(g2_start), .g2_pause(g2_pause), .g2_win(g2_win), .g2_lose(g2_lose),
        .game1_state(h0_game1_state), .game2_state(h0_game2_state),
        .g1_wins(h0_g1_wins), .g1_losses(h0_g1_losses),
        .g2_wins(h0_g2_wins), .g2_losses(h0_g2_losses)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge; events driven before the call are one-cycle pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        {g1_start, g1_pause, g1_win, g1_lose} = 4'b0;
        {g2_start, g2_pause, g2_win, g2_lose} = 4'b0;
        rst = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        int bad;
        // 1: reset with random events
        #1;
        for (int i = 0; i < 2; i++) begin
            rst = 1'b1;
            {g1_start, g1_pause, g1_win, g1_lose} = 4'($urandom);
            {g2_start, g2_pause, g2_win, g2_lose} = 4'($urandom);
            @(posedge clk);
            #1;
        end
        {g1_start, g1_pause, g1_win, g1_lose} = 4'b0;
        {g2_start, g2_pause, g2_win, g2_lose} = 4'b0;
        check("rst_g1", game1_state, 0);
        check("rst_g2", game2_state, 0);
        check("rst_cnt", {g1_wins, g1_losses, g2_wins, g2_losses}, 0);
        rst = 1'b0;
        tick(); tick();
        check("idle_g1", game1_state, 0);
        check("idle_g2", game2_state, 0);

        // 2: run, win, hold 4 cycles, auto-pause
        g1_start = 1; tick();
        check("start_run", game1_state, 3);
        tick(); tick();
        check("still_run", game1_state, 3);
        g1_win = 1; tick();
        check("win_c1", game1_state, 1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("win_c%0d", i), game1_state, 1);
        end
        tick();
        check("win_expire", game1_state, 0);
        check("wins_1", g1_wins, SC);
        check("g2_untouched", game2_state, 0);

        // 3: simultaneous events, start on expiry cycle
        do_reset();
        g1_start = 1; tick();
        g1_win = 1; g1_lose = 1; g1_pause = 1; tick();
        check("sim_lose", game1_state, 2);
        check("sim_losses", g1_losses, SC);
        check("sim_wins", g1_wins, 0);
        tick(); tick(); tick();
        check("lose_held", game1_state, 2);
        g1_start = 1; tick();
        check("start_beats_expiry", game1_state, 3);

        // 4: pause toggle on game2
        do_reset();
        g2_start = 1; tick();
        check("g2_run", game2_state, 3);
        g2_pause = 1; tick();
        check("g2_paused", game2_state, 0);
        g2_win = 1; tick();
        check("g2_win_ignored", game2_state, 0);
        check("g2_no_count", g2_wins, 0);
        g2_pause = 1; tick();
        check("g2_resume", game2_state, 3);
        check("g1_isolated", game1_state, 0);
        g2_start = 1; tick();
        check("g2_start_ignored", game2_state, 3);

        // 5: saturation
        do_reset();
        g1_start = 1; tick();
        for (int i = 0; i < 5; i++) begin
            g1_win = 1; tick();
            g1_start = 1; tick();
            if (i == 1) check("wins_2", g1_wins, 2 * SC);
        end
        check("wins_sat", g1_wins, 3 * SC);
        check("losses_sat0", g1_losses, 0);

        // 6: no-expiry hold, then reset mid-hold
        do_reset();
        g1_start = 1; tick();
        g1_win = 1; tick();
        check("h0_win", h0_game1_state, 1);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (h0_game1_state != 2'd1) bad++;
        end
        check("h0_held_1000", bad, 0);
        g1_pause = 1; g1_win = 1; g1_lose = 1; tick();
        check("h0_ignore", h0_game1_state, 1);
        g1_start = 1; tick();
        check("h0_start", h0_game1_state, 3);
        g1_lose = 1; tick();
        check("h0_lose", h0_game1_state, 2);
        tick();
        rst = 1'b1; g1_start = 1; tick();
        check("h0_rst_mid_hold", h0_game1_state, 0);
        check("h0_rst_cnt", h0_g1_losses, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
